// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its read-side checker.
// Operand, opcode, address, instruction and result types plus reader state.
package instr_register_pkg;

    localparam int ADDR_W = 5;

    typedef logic signed [31:0] operand_t;
    typedef logic [ADDR_W-1:0] address_t;
    typedef logic signed [63:0] result_t;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rez;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

    localparam logic [5:0] MAX_ERR = 6'd63;

endpackage

// File: rtl/instr_result_model.sv
// Golden result for one instruction: signed 64-bit arithmetic on the operands.
// Division by zero is not evaluated; skip_o flags it instead.
module instr_result_model
    import instr_register_pkg::*;
(
    input  opcode_t  opc_i,
    input  operand_t a_i,
    input  operand_t b_i,
    output result_t  expected_o,
    output logic     skip_o
);

    result_t a_w;
    result_t b_w;

    assign a_w = {{32{a_i[31]}}, a_i};
    assign b_w = {{32{b_i[31]}}, b_i};

    always_comb begin
        expected_o = '0;
        skip_o     = 1'b0;
        case (opc_i)
            ZERO:  expected_o = '0;
            PASSA: expected_o = a_w;
            PASSB: expected_o = b_w;
            ADD:   expected_o = a_w + b_w;
            SUB:   expected_o = a_w - b_w;
            MULT:  expected_o = a_w * b_w;
            DIV: begin
                if (b_w == '0) skip_o = 1'b1;
                else           expected_o = a_w / b_w;
            end
            MOD: begin
                if (b_w == '0) skip_o = 1'b1;
                else           expected_o = a_w % b_w;
            end
            default: expected_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_reader.sv
// Scans a range of instruction register entries, checks each stored result
// and streams the captured words out on a valid/ready port.
module instr_reader
    import instr_register_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  address_t     start_ptr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         out_valid,
    input  logic         out_ready,
    output instruction_t out_instr,
    output address_t     out_ptr,
    output logic         out_mismatch,
    output logic         out_skip,
    output logic         busy,
    output logic         done,
    output logic [5:0]   err_count
);

    reader_state_t state_q, state_d;
    address_t      rp_q, rp_d;
    logic [5:0]    rem_q, rem_d;
    logic          ov_q, ov_d;
    instruction_t  oi_q, oi_d;
    address_t      optr_q, optr_d;
    logic          mm_q, mm_d;
    logic          sk_q, sk_d;
    logic [5:0]    err_q, err_d;
    logic          done_q, done_d;

    result_t exp_rez;
    logic    exp_skip;
    logic    cap;
    logic    acc;
    logic    mm_now;

    instr_result_model u_model (
        .opc_i      (instruction_word.opc),
        .a_i        (instruction_word.op_a),
        .b_i        (instruction_word.op_b),
        .expected_o (exp_rez),
        .skip_o     (exp_skip)
    );

    // A new word may enter only when the output slot is empty or draining.
    assign cap    = (state_q == RUN) && (!ov_q || out_ready);
    assign acc    = ov_q && out_ready;
    assign mm_now = !exp_skip && (instruction_word.rez != exp_rez);

    always_comb begin
        state_d = state_q;
        rp_d    = rp_q;
        rem_d   = rem_q;
        ov_d    = ov_q;
        oi_d    = oi_q;
        optr_d  = optr_q;
        mm_d    = mm_q;
        sk_d    = sk_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count != 6'd0) begin
                        state_d = RUN;
                        rp_d    = start_ptr;
                        rem_d   = count;
                        err_d   = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (cap && rem_q == 6'd1) state_d = DRAIN;
            end
            DRAIN: begin
                if (!ov_q || acc) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (cap) begin
            oi_d   = instruction_word;
            optr_d = rp_q;
            ov_d   = 1'b1;
            mm_d   = mm_now;
            sk_d   = exp_skip;
            rem_d  = rem_q - 6'd1;
            if (rp_q == address_t'(DEPTH - 1)) rp_d = '0;
            else                               rp_d = rp_q + address_t'(1);
            if (mm_now && err_q != MAX_ERR) err_d = err_q + 6'd1;
        end else if (acc) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rp_q    <= '0;
            rem_q   <= '0;
            ov_q    <= 1'b0;
            oi_q    <= '0;
            optr_q  <= '0;
            mm_q    <= 1'b0;
            sk_q    <= 1'b0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rp_q    <= rp_d;
            rem_q   <= rem_d;
            ov_q    <= ov_d;
            oi_q    <= oi_d;
            optr_q  <= optr_d;
            mm_q    <= mm_d;
            sk_q    <= sk_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign read_pointer = rp_q;
    assign out_valid    = ov_q;
    assign out_instr    = oi_q;
    assign out_ptr      = optr_q;
    assign out_mismatch = mm_q;
    assign out_skip     = sk_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_instr_reader.sv
// Bench for instr_reader: a register-array model, vector table, random scans
// with backpressure and a high-level result/scan reference.
module tb_instr_reader;
    import instr_register_pkg::*;

    logic         clk;
    logic         reset;
    logic         start;
    address_t     start_ptr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         out_valid;
    logic         out_ready;
    instruction_t out_instr;
    address_t     out_ptr;
    logic         out_mismatch;
    logic         out_skip;
    logic         busy;
    logic         done;
    logic [5:0]   err_count;

    instruction_t mem [32];
    int total;
    int bad;

    assign instruction_word = mem[read_pointer];

    instr_reader #(.DEPTH(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_ptr        (start_ptr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_ptr          (out_ptr),
        .out_mismatch     (out_mismatch),
        .out_skip         (out_skip),
        .busy             (busy),
        .done             (done),
        .err_count        (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int      addr;
        opcode_t opc;
        int      a;
        int      b;
        longint  rez;
        bit      mm;
        bit      sk;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [135:0] act,
                       input logic [135:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic result_t ref_exp(input instruction_t w, output bit sk);
        longint a;
        longint b;
        a  = longint'(w.op_a);
        b  = longint'(w.op_b);
        sk = 1'b0;
        if (w.opc == PASSA) return a;
        if (w.opc == PASSB) return b;
        if (w.opc == ADD)   return a + b;
        if (w.opc == SUB)   return a - b;
        if (w.opc == MULT)  return a * b;
        if (w.opc == DIV || w.opc == MOD) begin
            if (b == 0) begin
                sk = 1'b1;
                return 0;
            end
            return (w.opc == DIV) ? a / b : a % b;
        end
        return 0;
    endfunction

    function automatic bit ref_mm(input instruction_t w, output bit sk);
        result_t e;
        e = ref_exp(w, sk);
        return !sk && (w.rez != e);
    endfunction

    task automatic fill_random();
        bit sk;
        result_t e;
        for (int i = 0; i < 32; i++) begin
            mem[i].opc  = opcode_t'(4'($urandom_range(0, 9)));
            mem[i].op_a = operand_t'($urandom_range(0, 40)) - 20;
            if ($urandom_range(0, 3) == 0) mem[i].op_b = '0;
            else mem[i].op_b = operand_t'($urandom_range(0, 40)) - 20;
            e = ref_exp(mem[i], sk);
            mem[i].rez = ($urandom_range(0, 2) == 0) ? e + 1 : e;
        end
    endtask

    task automatic run_scan(input int sp, input int n, input int mode);
        bit pat [4];
        int got;
        int cyc;
        int exp_err;
        int ptr;
        bit sk;
        bit mm;
        bit stall;
        bit seen_done;
        instruction_t held;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_err = 0;
        for (int k = 0; k < n; k++)
            if (ref_mm(mem[(sp + k) % 32], sk)) exp_err++;
        if (exp_err > 63) exp_err = 63;
        start_ptr = address_t'(sp);
        count     = 6'(n);
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        got = 0;
        cyc = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 400) begin
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = pat[cyc % 4];
            else                out_ready = 1'($urandom_range(0, 1));
            if (mode == 2 && cyc == 2) begin
                start     = 1'b1;
                start_ptr = address_t'(sp + 5);
                count     = 6'd3;
            end else begin
                start = 1'b0;
            end
            stall = out_valid && !out_ready;
            held  = out_instr;
            if (out_valid && out_ready) begin
                if (got >= n) begin
                    chk("extra_beat", got, n - 1);
                end else begin
                    ptr = (sp + got) % 32;
                    mm  = ref_mm(mem[ptr], sk);
                    chk("beat_ptr", out_ptr, ptr);
                    chk("beat_instr", out_instr, mem[ptr]);
                    chk("beat_mm", out_mismatch, mm);
                    chk("beat_skip", out_skip, sk);
                end
                got++;
            end
            step();
            cyc++;
            if (stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_instr", out_instr, held);
            end
            seen_done = done;
        end
        start = 1'b0;
        chk("scan_done", seen_done, 1'b1);
        chk("beats", got, n);
        chk("err_count", err_count, exp_err);
        chk("busy_at_done", busy, 1'b0);
        if (mode == 0) chk("done_latency", cyc, n + 2);
    endtask

    vec_t tbl [12];

    initial begin
        bit any_done;
        bit seen;
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        start     = 1'b0;
        start_ptr = '0;
        count     = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rp", read_pointer, 0);
        chk("rst_err", err_count, 0);
        chk("rst_flags", {out_mismatch, out_skip, out_ptr}, 0);
        chk("rst_instr", out_instr, 0);

        mem[2] = '{ADD, 32'sd5, 32'sd3, 64'sd8};
        run_scan(2, 1, 0);

        tbl[0]  = '{2,  ADD,   5,  3,  8,  1'b0, 1'b0};
        tbl[1]  = '{9,  MULT,  3,  4,  11, 1'b1, 1'b0};
        tbl[2]  = '{6,  SUB,   9,  9,  0,  1'b0, 1'b0};
        tbl[3]  = '{5,  DIV,   7,  0,  77, 1'b0, 1'b1};
        tbl[4]  = '{10, DIV,   -7, 2,  -3, 1'b0, 1'b0};
        tbl[5]  = '{11, MOD,   -7, 2,  -1, 1'b0, 1'b0};
        tbl[6]  = '{12, MOD,   7,  0,  99, 1'b0, 1'b1};
        tbl[7]  = '{31, ZERO,  4,  4,  1,  1'b1, 1'b0};
        tbl[8]  = '{0,  opcode_t'(4'd12), 1, 2, 0, 1'b0, 1'b0};
        tbl[9]  = '{1,  opcode_t'(4'd12), 1, 2, 5, 1'b1, 1'b0};
        tbl[10] = '{3,  PASSB, 0,  -4, -4, 1'b0, 1'b0};
        tbl[11] = '{4,  MULT,  32'h7fffffff, 2, 64'd4294967294, 1'b0, 1'b0};

        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            mem[tbl[i].addr] = '{tbl[i].opc, operand_t'(tbl[i].a),
                                 operand_t'(tbl[i].b), result_t'(tbl[i].rez)};
            start_ptr = address_t'(tbl[i].addr);
            count     = 6'd1;
            start     = 1'b1;
            step();
            start = 1'b0;
            step();
            chk("tbl_valid", out_valid, 1'b1);
            chk("tbl_ptr", out_ptr, tbl[i].addr);
            chk("tbl_mm", out_mismatch, tbl[i].mm);
            chk("tbl_skip", out_skip, tbl[i].sk);
            chk("tbl_err", err_count, tbl[i].mm);
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                step();
                seen = done;
            end
            chk("tbl_done", seen, 1'b1);
        end

        fill_random();
        run_scan(28, 8, 0);
        run_scan(28, 8, 1);
        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_scan(int'($urandom_range(0, 31)), int'($urandom_range(1, 32)), 2);
        end
        run_scan(0, 32, 1);

        start_ptr = 5'd7;
        count     = 6'd0;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk("c0_busy", busy, 1'b1);
        chk("c0_done_early", done, 1'b0);
        step();
        chk("c0_done", done, 1'b1);
        chk("c0_valid", out_valid, 1'b0);
        step();
        chk("c0_idle", {busy, done}, 2'b00);

        fill_random();
        out_ready = 1'b1;
        start_ptr = 5'd0;
        count     = 6'd10;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rs_valid", out_valid, 1'b0);
        chk("rs_busy", busy, 1'b0);
        chk("rs_rp", read_pointer, 0);
        chk("rs_out", {out_ptr, out_mismatch, out_skip, err_count}, 0);
        any_done = done;
        for (int c = 0; c < 12; c++) begin
            step();
            any_done = any_done | done;
        end
        chk("rs_no_done", any_done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
